// File: rtl/fbuff_arbiter.sv
// fbuff_arbiter: shares the single-port frame buffer between the display line
// fetcher (WORDS_PER_LINE consecutive reads per request) and the host pixel writer.
// Optional feature macro FBUFF_ARB_INTERLEAVE_EN: when defined, a waiting host write
// is slotted in after each non-last read word; otherwise writes only start from IDLE.
// The frame buffer's own active-low reset is tied to ~rst_i at integration.
//
// state   | meaning
// INIT    | two cycles after reset release, frame buffer settling, busy
// IDLE    | nothing in flight, accepts line requests and host writes
// RD_REQ  | one-cycle read request for word base+word
// RD_WAIT | read request issued, waiting for the response
// WRITE   | one-cycle host write (or discard when out of range), ack pulse
module fbuff_arbiter #(
    parameter int FBUFF_ADDR_WIDTH = 12,
    parameter int FBUFF_WIDTH      = 60,
    parameter int FBUFF_DEPTH      = 3840,
    parameter int WORDS_PER_LINE   = 8,
    parameter int LINE_IDX_WIDTH   = 9
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                line_req_i,
    input  logic [LINE_IDX_WIDTH-1:0]           line_idx_i,
    output logic                                line_busy_o,
    output logic [FBUFF_WIDTH-1:0]              line_data_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0]   line_word_o,
    output logic                                line_valid_o,
    output logic                                line_done_o,
    output logic                                line_err_o,
    input  logic                                wr_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0]         wr_addr_i,
    input  logic [FBUFF_WIDTH-1:0]              wr_data_i,
    output logic                                wr_ack_o,
    output logic [FBUFF_ADDR_WIDTH-1:0]         fbuff_addr_o,
    output logic [FBUFF_WIDTH-1:0]              fbuff_data_o,
    output logic                                fbuff_we_o,
    output logic                                fbuff_en_o,
    output logic                                fbuff_rd_req_o,
    input  logic                                fbuff_rd_rsp_i,
    input  logic [FBUFF_WIDTH-1:0]              fbuff_data_i
);

    localparam int LINES      = FBUFF_DEPTH / WORDS_PER_LINE;
    localparam int WORD_WIDTH = $clog2(WORDS_PER_LINE);
    localparam logic [WORD_WIDTH-1:0] LAST_WORD = WORD_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {INIT, IDLE, RD_REQ, RD_WAIT, WRITE} state_t;

    state_t                      state;
    logic                        init_cnt;
    logic [FBUFF_ADDR_WIDTH-1:0] base;
    logic [WORD_WIDTH-1:0]       word;

    logic                        idx_ok;
    logic                        accept;
    logic                        wr_in_range;
    logic [FBUFF_ADDR_WIDTH-1:0] req_base;
    logic [FBUFF_ADDR_WIDTH-1:0] cur_addr;
    logic [FBUFF_ADDR_WIDTH-1:0] next_addr;

    assign idx_ok      = 32'(line_idx_i) < LINES;
    // Only states with busy low (IDLE, or a write issued from IDLE) can take a new line.
    assign accept      = line_req_i && !line_busy_o && idx_ok;
    assign wr_in_range = 32'(wr_addr_i) < FBUFF_DEPTH;
    assign req_base    = FBUFF_ADDR_WIDTH'(line_idx_i) * FBUFF_ADDR_WIDTH'(WORDS_PER_LINE);
    assign cur_addr    = base + FBUFF_ADDR_WIDTH'(word);
    assign next_addr   = cur_addr + FBUFF_ADDR_WIDTH'(1);

    // Sequencer: state, fetch bookkeeping and every registered output
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= INIT;
            init_cnt       <= 1'b0;
            base           <= '0;
            word           <= '0;
            line_busy_o    <= 1'b1;
            line_data_o    <= '0;
            line_word_o    <= '0;
            line_valid_o   <= 1'b0;
            line_done_o    <= 1'b0;
            line_err_o     <= 1'b0;
            wr_ack_o       <= 1'b0;
            fbuff_addr_o   <= '0;
            fbuff_data_o   <= '0;
            fbuff_we_o     <= 1'b0;
            fbuff_en_o     <= 1'b0;
            fbuff_rd_req_o <= 1'b0;
        end else begin
            line_valid_o   <= 1'b0;
            line_done_o    <= 1'b0;
            wr_ack_o       <= 1'b0;
            fbuff_we_o     <= 1'b0;
            fbuff_rd_req_o <= 1'b0;
            line_err_o     <= line_req_i && (line_busy_o || !idx_ok);

            case (state)
                INIT: begin
                    init_cnt <= 1'b1;
                    if (init_cnt) begin
                        state       <= IDLE;
                        line_busy_o <= 1'b0;
                    end
                end

                IDLE: begin
                    if (accept) begin
                        base           <= req_base;
                        word           <= '0;
                        line_busy_o    <= 1'b1;
                        state          <= RD_REQ;
                        fbuff_en_o     <= 1'b1;
                        fbuff_addr_o   <= req_base;
                        fbuff_rd_req_o <= 1'b1;
                    end else if (wr_req_i) begin
                        state        <= WRITE;
                        fbuff_en_o   <= 1'b1;
                        fbuff_we_o   <= wr_in_range;
                        fbuff_addr_o <= wr_addr_i;
                        fbuff_data_o <= wr_data_i;
                        wr_ack_o     <= 1'b1;
                    end
                end

                RD_REQ: begin
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (fbuff_rd_rsp_i) begin
                        line_data_o  <= fbuff_data_i;
                        line_word_o  <= word;
                        line_valid_o <= 1'b1;
                        if (word == LAST_WORD) begin
                            line_done_o <= 1'b1;
                            line_busy_o <= 1'b0;
                            state       <= IDLE;
                            fbuff_en_o  <= 1'b0;
                        end else begin
                            word <= word + WORD_WIDTH'(1);
`ifdef FBUFF_ARB_INTERLEAVE_EN
                            if (wr_req_i) begin
                                state        <= WRITE;
                                fbuff_we_o   <= wr_in_range;
                                fbuff_addr_o <= wr_addr_i;
                                fbuff_data_o <= wr_data_i;
                                wr_ack_o     <= 1'b1;
                            end else
`endif
                            begin
                                state          <= RD_REQ;
                                fbuff_addr_o   <= next_addr;
                                fbuff_rd_req_o <= 1'b1;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (line_busy_o) begin
                        state          <= RD_REQ;
                        fbuff_addr_o   <= cur_addr;
                        fbuff_rd_req_o <= 1'b1;
                    end else if (accept) begin
                        base           <= req_base;
                        word           <= '0;
                        line_busy_o    <= 1'b1;
                        state          <= RD_REQ;
                        fbuff_addr_o   <= req_base;
                        fbuff_rd_req_o <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        fbuff_en_o <= 1'b0;
                    end
                end

                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fbuff_arbiter.sv
// Testbench for fbuff_arbiter: frame buffer model with random read latency, an
// independent reference memory image, and a per-cycle scoreboard for line output,
// read addresses and write acks.
module tb_fbuff_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 60;
    localparam int DEPTH = 3840;
    localparam int WPL   = 8;
    localparam int IW    = 9;
    localparam int LINES = DEPTH / WPL;

    logic          clk;
    logic          rst;
    logic          line_req;
    logic [IW-1:0] line_idx;
    logic          line_busy;
    logic [DW-1:0] line_data;
    logic [2:0]    line_word;
    logic          line_valid;
    logic          line_done;
    logic          line_err;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] fbuff_addr;
    logic [DW-1:0] fbuff_wdata;
    logic          fbuff_we;
    logic          fbuff_en;
    logic          fbuff_rd_req;
    logic          fbuff_rd_rsp = 1'b0;
    logic [DW-1:0] fbuff_rdata  = '0;

    fbuff_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .line_req_i     (line_req),
        .line_idx_i     (line_idx),
        .line_busy_o    (line_busy),
        .line_data_o    (line_data),
        .line_word_o    (line_word),
        .line_valid_o   (line_valid),
        .line_done_o    (line_done),
        .line_err_o     (line_err),
        .wr_req_i       (wr_req),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .wr_ack_o       (wr_ack),
        .fbuff_addr_o   (fbuff_addr),
        .fbuff_data_o   (fbuff_wdata),
        .fbuff_we_o     (fbuff_we),
        .fbuff_en_o     (fbuff_en),
        .fbuff_rd_req_o (fbuff_rd_req),
        .fbuff_rd_rsp_i (fbuff_rd_rsp),
        .fbuff_data_i   (fbuff_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'((64'(i) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF);
    endfunction

    // Frame buffer model: 1-cycle writes, read response 0..3 cycles after the request cycle
    logic [DW-1:0] mem [DEPTH];
    logic          mem_ready = 1'b0;
    int            rsp_cnt   = 0;
    int            lat_now   = 0;
    int            lat_mode  = 0;
    logic [AW-1:0] rsp_addr  = '0;

    always @(posedge clk) begin
        fbuff_rd_rsp <= 1'b0;
        if (rst) begin
            rsp_cnt <= 0;
            if (!mem_ready) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
                mem_ready <= 1'b1;
            end
        end else begin
            if (fbuff_en && fbuff_we && (int'(fbuff_addr) < DEPTH))
                mem[fbuff_addr] <= fbuff_wdata;
            if (fbuff_rd_req) begin
                lat_now = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                if (lat_now == 0) begin
                    fbuff_rd_rsp <= 1'b1;
                    fbuff_rdata  <= mem[fbuff_addr];
                end else begin
                    rsp_cnt  <= lat_now;
                    rsp_addr <= fbuff_addr;
                end
            end else if (rsp_cnt > 0) begin
                rsp_cnt <= rsp_cnt - 1;
                if (rsp_cnt == 1) begin
                    fbuff_rd_rsp <= 1'b1;
                    fbuff_rdata  <= mem[rsp_addr];
                end
            end
        end
    end

    // Reference: what the frame buffer should hold, and what each line fetch should produce
    typedef struct {
        logic [2:0]    word;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          exp_q [$];
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] got_line [WPL];
    int            rdreq_cyc [WPL];
    int            valid0_cyc = 0;
    int            done_cyc   = 0;
    int            ack_cyc    = 0;
    int            n_valid    = 0;
    int            n_done     = 0;

    // Advance one cycle and score everything the DUT presented in it
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (line_valid) begin
                n_valid++;
                check_val("valid_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("line_word", 64'(line_word), 64'(e.word));
                    check_val("line_data", 64'(line_data), 64'(e.data));
                    check_val("line_done", 64'(line_done), 64'(e.done));
                    got_line[line_word] = line_data;
                    if (line_word == 3'd0) valid0_cyc = cyc;
                end
            end
            if (line_done) begin
                n_done++;
                done_cyc = cyc;
                check_val("done_with_valid", 64'(line_valid), 64'(1));
            end
            if (fbuff_rd_req) begin
                check_val("rdreq_expected", 64'(addr_q.size() != 0), 64'(1));
                if (addr_q.size() != 0) check_val("rd_addr", 64'(fbuff_addr), 64'(addr_q.pop_front()));
                check_val("rd_no_we", 64'(fbuff_we), 64'(0));
                check_val("rd_en", 64'(fbuff_en), 64'(1));
                rdreq_cyc[int'(fbuff_addr) % WPL] = cyc;
            end
            if (wr_ack) begin
                ack_cyc = cyc;
                check_val("ack_expected", 64'(wr_req), 64'(1));
                if (wr_req) begin
                    check_val("wr_en", 64'(fbuff_en), 64'(1));
                    check_val("wr_we", 64'(fbuff_we), 64'(int'(wr_addr) < DEPTH));
                    check_val("wr_addr", 64'(fbuff_addr), 64'(wr_addr));
                    if (int'(wr_addr) < DEPTH) begin
                        check_val("wr_data", 64'(fbuff_wdata), 64'(wr_data));
                        ref_mem[wr_addr] = wr_data;
                    end
                    wr_req = 1'b0;
                end
            end
        end
    endtask

    task automatic start_fetch(input int idx);
        line_req = 1'b1;
        line_idx = IW'(idx);
        if (idx < LINES) begin
            for (int w = 0; w < WPL; w++) begin
                exp_q.push_back('{word: 3'(w), data: ref_mem[idx * WPL + w], done: (w == WPL - 1)});
                addr_q.push_back(AW'(idx * WPL + w));
            end
        end
        tick();
        line_req = 1'b0;
    endtask

    task automatic start_write(input int addr, input logic [DW-1:0] data);
        wr_req  = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (wr_req || exp_q.size() != 0); i++) tick();
        check_val("idle_wr_done", 64'(wr_req), 64'(0));
        check_val("idle_line_done", 64'(exp_q.size()), 64'(0));
    endtask

    int  v_mark;
    int  d_mark;
    int  r_idx;
    int  r_addr;
    bit  seen;

    initial begin
        rst      = 1'b1;
        line_req = 1'b0;
        line_idx = '0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        lat_mode = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        repeat (3) tick();
        check_val("rst_busy", 64'(line_busy), 64'(1));
        check_val("rst_valid", 64'(line_valid), 64'(0));
        check_val("rst_done", 64'(line_done), 64'(0));
        check_val("rst_err", 64'(line_err), 64'(0));
        check_val("rst_ack", 64'(wr_ack), 64'(0));
        check_val("rst_en", 64'(fbuff_en), 64'(0));
        check_val("rst_we", 64'(fbuff_we), 64'(0));
        check_val("rst_rdreq", 64'(fbuff_rd_req), 64'(0));
        check_val("rst_addr", 64'(fbuff_addr), 64'(0));
        check_val("rst_data", 64'(line_data), 64'(0));

        // Reset release with a line request in the first INIT cycle
        rst      = 1'b0;
        line_req = 1'b1;
        line_idx = '0;
        tick();
        line_req = 1'b0;
        check_val("init_busy_c1", 64'(line_busy), 64'(1));
        check_val("init_req_err", 64'(line_err), 64'(1));
        check_val("init_no_en", 64'(fbuff_en), 64'(0));
        tick();
        check_val("idle_busy", 64'(line_busy), 64'(0));
        check_val("idle_err_clear", 64'(line_err), 64'(0));
        check_val("idle_no_en", 64'(fbuff_en), 64'(0));

        // Line 3 with immediate responses: addresses 24..31, words 0..7, done on word 7
        v_mark = n_valid;
        d_mark = n_done;
        start_fetch(3);
        wait_idle();
        check_val("l3_valid_count", 64'(n_valid - v_mark), 64'(8));
        check_val("l3_done_count", 64'(n_done - d_mark), 64'(1));
        check_val("l3_busy_after", 64'(line_busy), 64'(0));

        // Host write from IDLE, then read back through a line fetch
        start_write('h100, DW'('hABC));
        wait_idle();
        tick();
        check_val("wr_we_one_cycle", 64'(fbuff_we), 64'(0));
        start_fetch('h100 / WPL);
        wait_idle();
        check_val("wr_readback", 64'(got_line[0]), 64'('hABC));

        // Write held across a line fetch
        start_write('h200, DW'({$urandom(), $urandom()}));
        start_fetch(5);
        wait_idle();
`ifdef FBUFF_ARB_INTERLEAVE_EN
        check_val("ilv_ack_after_w0", 64'(ack_cyc >= valid0_cyc), 64'(1));
        check_val("ilv_ack_before_rd1", 64'(ack_cyc < rdreq_cyc[1]), 64'(1));
`else
        check_val("strict_ack_after_done", 64'(ack_cyc), 64'(done_cyc + 1));
`endif

        // Out-of-range line index: error pulse, frame buffer untouched
        line_req = 1'b1;
        line_idx = IW'(LINES);
        tick();
        line_req = 1'b0;
        check_val("bad_idx_err", 64'(line_err), 64'(1));
        check_val("bad_idx_no_en", 64'(fbuff_en), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("bad_idx_quiet", 64'(fbuff_en), 64'(0));
        end

        // Boundaries: last line, last word address, first out-of-range write
        start_fetch(LINES - 1);
        wait_idle();
        start_write(DEPTH - 1, DW'({$urandom(), $urandom()}));
        wait_idle();
        start_write(DEPTH, DW'({$urandom(), $urandom()}));
        wait_idle();
        start_fetch(LINES - 1);
        wait_idle();

        // Request while a fetch is in flight is rejected
        lat_mode = 2;
        start_fetch(7);
        repeat (3) tick();
        line_req = 1'b1;
        line_idx = IW'(9);
        tick();
        line_req = 1'b0;
        check_val("busy_req_err", 64'(line_err), 64'(1));
        wait_idle();

        // Randomized traffic against the reference image
        lat_mode = -1;
        for (int it = 0; it < 40; it++) begin
            r_idx  = int'($urandom_range(0, LINES - 1));
            r_addr = int'($urandom_range(0, 4095));
            case ($urandom_range(0, 3))
                0: start_fetch(r_idx);
                1: start_write(r_addr, DW'({$urandom(), $urandom()}));
                2: begin
                    if (r_addr >= r_idx * WPL && r_addr < r_idx * WPL + WPL) r_addr += WPL;
                    start_write(r_addr, DW'({$urandom(), $urandom()}));
                    start_fetch(r_idx);
                end
                default: begin
                    line_req = 1'b1;
                    line_idx = IW'($urandom_range(LINES, 511));
                    tick();
                    line_req = 1'b0;
                    check_val("rand_bad_idx_err", 64'(line_err), 64'(1));
                end
            endcase
            wait_idle();
        end

        // Reset while waiting on word 4 aborts the fetch
        lat_mode = 3;
        start_fetch(10);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (fbuff_rd_req && fbuff_addr == AW'(10 * WPL + 4)) seen = 1'b1;
        end
        check_val("abort_saw_word4_req", 64'(seen), 64'(1));
        tick();
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        v_mark = n_valid;
        d_mark = n_done;
        repeat (3) tick();
        check_val("abort_busy_in_rst", 64'(line_busy), 64'(1));
        rst = 1'b0;
        for (int i = 0; i < 10 && line_busy; i++) tick();
        check_val("abort_reinit_idle", 64'(line_busy), 64'(0));
        repeat (4) tick();
        check_val("abort_no_valid", 64'(n_valid - v_mark), 64'(0));
        check_val("abort_no_done", 64'(n_done - d_mark), 64'(0));
        lat_mode = 0;
        v_mark = n_valid;
        start_fetch(0);
        wait_idle();
        check_val("abort_refetch_count", 64'(n_valid - v_mark), 64'(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
